// File: rtl/seg_pkg.sv
// Shared 7-segment definitions for the display encoder and the scan-capture decoder.
package seg_pkg;
  // disp bit positions: [7:1] = a..g, [0] = dot
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_ERR   = 4'hE;

  typedef enum logic {IDLE, COLLECT} frm_state_e;
endpackage

// File: rtl/seg_pattern_decode.sv
// Inverse of the segment encoder: a..g pattern to BCD, blank to 4'hF, anything else flagged.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] dig,
  output logic       err
);
  always_comb begin
    err = 1'b0;
    case (seg)
      SEG_0:     dig = 4'd0;
      SEG_1:     dig = 4'd1;
      SEG_2:     dig = 4'd2;
      SEG_3:     dig = 4'd3;
      SEG_4:     dig = 4'd4;
      SEG_5:     dig = 4'd5;
      SEG_6:     dig = 4'd6;
      SEG_7:     dig = 4'd7;
      SEG_8:     dig = 4'd8;
      SEG_9:     dig = 4'd9;
      SEG_BLANK: dig = DIG_BLANK;
      default: begin
        dig = DIG_ERR;
        err = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/seg_scan_capture.sv
// Snoops a multiplexed 7-segment bus, captures each digit after a stable dwell
// and assembles complete frames in scan order.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int NDIG   = 8,
  parameter int STABLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        disp,
  input  logic [NDIG-1:0]   cat,
  output logic [4*NDIG-1:0] frame_digits,
  output logic [NDIG-1:0]   frame_dots,
  output logic              frame_err,
  output logic              frame_valid,
  output logic              sync_err
);
  localparam int             IW     = $clog2(NDIG);
  localparam logic [7:0]     CNT_EV = 8'(STABLE - 1);
  localparam logic [7:0]     CNT_MX = 8'(STABLE);
  localparam logic [IW-1:0]  LAST   = IW'(NDIG - 1);

  logic [7:0]      r_disp, p_disp, cnt;
  logic [NDIG-1:0] r_cat, p_cat;

  // Select lines idle high so reset does not look like a multi-select fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp <= '0;
      r_cat  <= '1;
      p_disp <= '0;
      p_cat  <= '1;
      cnt    <= '0;
    end else begin
      r_disp <= disp;
      r_cat  <= cat;
      p_disp <= r_disp;
      p_cat  <= r_cat;
      if ({r_cat, r_disp} != {p_cat, p_disp}) cnt <= '0;
      else if (cnt != CNT_MX)                 cnt <= cnt + 8'd1;
    end
  end

  // p_* holds the pair just confirmed equal, so decode it rather than r_*.
  logic ev;
  assign ev = (cnt == CNT_EV);

  logic [3:0]    nz;
  logic [IW-1:0] idx;
  always_comb begin
    nz  = '0;
    idx = '0;
    for (int k = 0; k < NDIG; k++)
      if (!p_cat[k]) begin
        nz  = nz + 4'd1;
        idx = IW'(k);
      end
  end

  logic [3:0] dig;
  logic       derr;
  seg_pattern_decode u_dec (.seg(p_disp[SEG_A:SEG_G]), .dig(dig), .err(derr));

  frm_state_e               state, state_n;
  logic [IW-1:0]            expd, expd_n;
  logic [NDIG-1:0][3:0]     sh_dig, dig_n;
  logic [NDIG-1:0]          sh_dot, dot_n, sh_err, err_n;
  logic                     store, done, serr;

  always_comb begin
    state_n = state;
    expd_n  = expd;
    dig_n   = sh_dig;
    dot_n   = sh_dot;
    err_n   = sh_err;
    store   = 1'b0;
    done    = 1'b0;
    serr    = 1'b0;
    if (ev && nz > 4'd1) serr = 1'b1;
    else if (ev && nz == 4'd1) begin
      case (state)
        IDLE: if (idx == '0) begin
          store   = 1'b1;
          err_n   = '0;
          expd_n  = IW'(1);
          state_n = COLLECT;
        end
        COLLECT: begin
          if (idx == expd) begin
            store = 1'b1;
            if (expd == LAST) begin
              done    = 1'b1;
              state_n = IDLE;
              expd_n  = '0;
            end else expd_n = IW'(expd + 1'b1);
          end else if (idx == IW'(expd - 1'b1)) store = 1'b1;
          else if (idx == '0) begin
            store  = 1'b1;
            err_n  = '0;
            expd_n = IW'(1);
            serr   = 1'b1;
          end else begin
            serr    = 1'b1;
            state_n = IDLE;
            expd_n  = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    if (store) begin
      dig_n[idx] = dig;
      dot_n[idx] = p_disp[SEG_DP];
      err_n[idx] = derr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      expd         <= '0;
      sh_dig       <= '0;
      sh_dot       <= '0;
      sh_err       <= '0;
      frame_digits <= '0;
      frame_dots   <= '0;
      frame_err    <= 1'b0;
      frame_valid  <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      state       <= state_n;
      expd        <= expd_n;
      sh_dig      <= dig_n;
      sh_dot      <= dot_n;
      sh_err      <= done ? '0 : err_n;
      frame_valid <= done;
      sync_err    <= serr;
      if (done) begin
        frame_digits <= dig_n;
        frame_dots   <= dot_n;
        frame_err    <= |err_n;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed frame table plus hand sequences for glitch, latency, order faults and reset.
module tb_seg_scan_capture;
  localparam int NDIG   = 8;
  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  disp = 8'h00;
  logic [7:0]  cat = 8'hFF;
  logic [31:0] frame_digits;
  logic [7:0]  frame_dots;
  logic        frame_err, frame_valid, sync_err;

  seg_scan_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .disp(disp), .cat(cat),
    .frame_digits(frame_digits), .frame_dots(frame_dots), .frame_err(frame_err),
    .frame_valid(frame_valid), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int fv_cnt = 0, se_cnt = 0;
  always @(negedge clk) begin
    fv_cnt += int'(frame_valid);
    se_cnt += int'(sync_err);
  end

  typedef struct {
    logic [31:0] vals;     // value shown on digit i at [4i+3:4i]; F = blank, E = bad pattern
    logic [7:0]  dots;
    logic [31:0] exp_dig;
    logic        exp_err;
  } fvec_t;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      4'hF: return 7'b0000000;
      default: return 7'b1010101;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic show(input int i, input logic [3:0] v, input logic dot, input int n);
    cat  = ~(8'd1 << i);
    disp = {seg_of(v), dot};
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input logic [31:0] vals, input logic [7:0] dots);
    for (int i = 0; i < NDIG; i++) show(i, vals[4*i +: 4], dots[i], 10);
  endtask

  initial begin
    fvec_t tbl[5];
    int fv0, se0, hits, at;
    tbl[0] = '{32'h87654321, 8'h08, 32'h87654321, 1'b0};
    tbl[1] = '{32'h34567890, 8'hA5, 32'h34567890, 1'b0};
    tbl[2] = '{32'h87E54321, 8'h00, 32'h87E54321, 1'b1};
    tbl[3] = '{32'h87654321, 8'h00, 32'h87654321, 1'b0};
    tbl[4] = '{32'hF7654321, 8'h00, 32'hF7654321, 1'b0};

    repeat (3) @(negedge clk);
    check("reset digits", frame_digits, 32'h0);
    check("reset dots", {24'h0, frame_dots}, 32'h0);
    check("reset err", {31'h0, frame_err}, 32'h0);
    check("reset valid", {31'h0, frame_valid}, 32'h0);
    check("reset sync_err", {31'h0, sync_err}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      fv0 = fv_cnt; se0 = se_cnt;
      run_frame(tbl[t].vals, tbl[t].dots);
      #1;
      check($sformatf("frame%0d valid pulses", t), fv_cnt - fv0, 1);
      check($sformatf("frame%0d digits", t), frame_digits, tbl[t].exp_dig);
      check($sformatf("frame%0d dots", t), {24'h0, frame_dots}, {24'h0, tbl[t].dots});
      check($sformatf("frame%0d err", t), {31'h0, frame_err}, {31'h0, tbl[t].exp_err});
      check($sformatf("frame%0d sync_err pulses", t), se_cnt - se0, 0);
      @(negedge clk);
    end

    // Two-cycle glitch inside digit 2's dwell
    fv0 = fv_cnt; se0 = se_cnt;
    show(0, 4'd9, 1'b0, 10);
    show(1, 4'd8, 1'b0, 10);
    show(2, 4'd3, 1'b0, 6);
    disp = 8'b0000_0010;
    repeat (2) @(negedge clk);
    show(2, 4'd3, 1'b0, 6);
    for (int i = 3; i < NDIG; i++) show(i, 4'(i + 1), 1'b0, 10);
    #1;
    check("glitch valid pulses", fv_cnt - fv0, 1);
    check("glitch digits", frame_digits, 32'h87654389);
    check("glitch sync_err pulses", se_cnt - se0, 0);
    @(negedge clk);

    // frame_valid exactly on the 6th edge after the last digit's pins change
    for (int i = 0; i < NDIG - 1; i++) show(i, 4'(i), 1'b0, 10);
    cat = 8'h7F; disp = {seg_of(4'd9), 1'b1};
    hits = 0; at = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (frame_valid) begin hits++; at = k; end
    end
    check("latency edge", at, 6);
    check("valid width", hits, 1);
    check("latency digits", frame_digits, 32'h96543210);
    check("latency dots", {24'h0, frame_dots}, 32'h80);
    @(negedge clk);

    // Scan order jump 0,1,2,5 then a multi-select dwell
    fv0 = fv_cnt; se0 = se_cnt;
    show(0, 4'd1, 1'b0, 10);
    show(1, 4'd2, 1'b0, 10);
    show(2, 4'd3, 1'b0, 10);
    show(5, 4'd6, 1'b0, 10);
    #1;
    check("order jump sync_err", se_cnt - se0, 1);
    check("order jump no frame", fv_cnt - fv0, 0);
    @(negedge clk);
    se0 = se_cnt;
    cat = 8'b1110_0111; disp = {seg_of(4'd1), 1'b0};
    repeat (10) @(negedge clk);
    #1;
    check("multi select sync_err", se_cnt - se0, 1);
    check("multi select no frame", fv_cnt - fv0, 0);
    @(negedge clk);
    run_frame(32'h87654321, 8'h00);
    #1;
    check("recover valid pulses", fv_cnt - fv0, 1);
    check("recover digits", frame_digits, 32'h87654321);
    @(negedge clk);

    // Reset after digit 4 captured
    for (int i = 0; i < 5; i++) show(i, 4'(7 - i), 1'b1, 10);
    #1; rst_n = 1'b0; #1;
    check("midreset digits", frame_digits, 32'h0);
    check("midreset dots", {24'h0, frame_dots}, 32'h0);
    check("midreset valid", {31'h0, frame_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    fv0 = fv_cnt;
    for (int i = 5; i < NDIG; i++) show(i, 4'(7 - i), 1'b0, 10);
    #1;
    check("resume no frame", fv_cnt - fv0, 0);
    check("resume digits held", frame_digits, 32'h0);
    @(negedge clk);
    run_frame(tbl[1].vals, tbl[1].dots);
    #1;
    check("post-reset valid pulses", fv_cnt - fv0, 1);
    check("post-reset digits", frame_digits, 32'h34567890);
    check("post-reset dots", {24'h0, frame_dots}, 32'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receiving end of the board's multiplexed 7-segment display bus. Snoops the segment lines and the digit-select lines, and samples each digit once its select has dwelt long enough.
- Inverts the segment code back to BCD, then assembles a complete NDIG-digit frame and presents it with a one-cycle valid strobe.
- Used for display self-check and for loop-back verification of the display driver path.

Parameters:
- NDIG, 8, number of multiplexed digits (2..8).
- STABLE, 4, consecutive identical registered samples of {cat,disp} required before a digit is captured (2..255).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- disp  input  8  segment lines, active-high; [7:1]=a..g, [0]=dot
- cat  input  NDIG  digit select, active-low, one-cold; cat[i]=0 selects digit i
- frame_digits  output  4*NDIG  digit i at [4i+3:4i]
- frame_dots  output  NDIG  dot bit of each digit
- frame_err  output  1  last frame held at least one undecodable pattern
- frame_valid  output  1  one-cycle pulse; frame outputs updated this cycle
- sync_err  output  1  one-cycle pulse on a scan-order or select-coding fault

Behaviour:
- Clock and reset
  - Single clock domain. rst_n=0 asynchronously clears all state and outputs.
  - frame_digits=0, frame_dots=0, frame_err=0, frame_valid=0, sync_err=0; FSM goes to IDLE; stability counter=0.
- Input stage
  - disp and cat are registered once (r_disp, r_cat). No further synchroniser is required; the lines come from an on-chip driver.
- Stability counter
  - Compares {r_cat,r_disp} with its value on the previous cycle. Any difference clears cnt to 0; equality increments cnt, saturating at STABLE.
  - A sample event fires on the single cycle in which cnt reaches STABLE-1 (the pair has been equal in STABLE registered samples).
  - One event per dwell. A change in disp alone starts a new dwell.
- Select decode
  - r_cat with exactly one zero gives index i.
  - Any other value, stable at the event (all ones = blanking interval, or multiple zeros), produces no capture.
  - Multiple zeros also pulse sync_err. All ones is silent.
- Segment decode of disp[7:1]
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9.
  - 0000000=blank, coded as 4'hF and not an error.
  - Any other pattern is coded as 4'hE and sets the per-frame error bit.
  - The dot is taken directly from disp[0].
- Frame FSM, states IDLE and COLLECT
  - IDLE: a capture with i=0 stores digit 0, sets exp=1 and goes to COLLECT. Captures with i≠0 are ignored silently (frame alignment).
  - COLLECT, i==exp: store the digit and set exp=exp+1.
  - COLLECT, i==exp-1 (re-dwell on the same digit): overwrite the digit, exp unchanged, no error.
  - COLLECT, i==0: restart the frame with digit 0 stored, exp=1, clear the error accumulator, pulse sync_err.
  - COLLECT, any other i: pulse sync_err, discard the partial frame, go to IDLE.
  - Completion: storing i==NDIG-1 copies the shadow buffer to the frame outputs and pulses frame_valid in the next cycle. The FSM then returns to IDLE, with exp=0 and the error accumulator cleared.
- Output rules
  - Frame outputs hold between frame_valid pulses.
  - Latency: frame_valid is high exactly 2 cycles after the clock edge on which the last digit's pins have been stable for STABLE edges (1 register stage, plus 1 output stage after the event).
  - sync_err and frame_valid may both assert in the same cycle.
  - rst_n asserted mid-frame discards the partial frame. The first frame after reset requires a fresh digit-0 capture.

Decomposition:
- Shared package seg_pkg holds:
  - segment code constants SEG_0..SEG_9 and SEG_BLANK;
  - DIG_BLANK=4'hF and DIG_ERR=4'hE;
  - bit positions SEG_A..SEG_G and SEG_DP.
- One natural sub-module, seg_pattern_decode: combinational 7-bit to 4-bit plus err flag. This is the inverse table of the team's segment encoder, kept separate so both sides share seg_pkg.

Test Plan:
- Clean scan, NDIG=8, STABLE=4: drive digits 0..7 showing "1 2 3 4 5 6 7 8", each held 10 cycles, dot on digit 3 only. Expect frame_digits=32'h87654321, frame_dots=8'h08, frame_err=0, and frame_valid pulsing once per scan.
- Glitch rejection: during digit 2, toggle disp to 0000001 for 2 cycles and then restore. Expect no spurious capture from the 2-cycle glitch, digit 2 still decoded correctly, and no sync_err.
- Bad pattern: digit 5 shows 1010101. Expect digit 5=4'hE and frame_err=1. The next clean frame gives frame_err=0.
- Blank digit: digit 7 = 0000000 with cat valid. Expect nibble 7=4'hF and frame_err=0.
- Order fault: scan 0,1,2 then jump to 5. Expect a sync_err pulse and no frame_valid until a full 0..7 sequence follows. A cat=8'b11100111 dwell pulses sync_err.
- Reset mid-frame: assert rst_n low after digit 4 is captured. Expect all outputs 0 immediately. Resuming the scan at digit 5 yields no frame until the next 0..7 pass.
